// File: rtl/accel_stream_arbiter_if.sv
// -----------------------------------------------------------------------------
// accel_stream_arbiter_if
//   AXI4-Stream bundle shared by the arbiter's two source ports and its single
//   accelerator-facing port.
//
//   Signals:
//     tdata  [DATA_WIDTH]  payload
//     tlast                end of frame
//     tvalid               producer has a beat
//     tready               consumer takes the beat
//     tid                  source index (only meaningful on the arbiter output)
//
//   Modports:
//     master  drives tdata/tlast/tvalid/tid, receives tready
//     slave   receives tdata/tlast/tvalid, drives tready
// -----------------------------------------------------------------------------
interface accel_stream_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;
  logic                  tid;

  modport master (output tdata, tlast, tvalid, tid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/accel_stream_arbiter.sv
// -----------------------------------------------------------------------------
// accel_stream_arbiter
//   Frame-granular round-robin arbiter that shares the single AXI-Stream input
//   of the accelerator between two stream sources. A grant is held for a whole
//   frame and released only when its last beat is accepted, so frames never
//   interleave. Frames longer than MAX_FRAME_LEN are cut by forcing tlast.
//
//   Ports:
//     s00_axis_aclk     clock for all interfaces
//     s00_axis_aresetn  synchronous active-low reset
//     s00_axis          source 0 stream (slave modport)
//     s01_axis          source 1 stream (slave modport)
//     m00_axis          stream to the accelerator (master modport), tid = source
//     frame_cnt0/1      frames completed per source, wrap modulo 2^CNT_WIDTH
//     trunc_err         sticky: some frame was cut at MAX_FRAME_LEN
// -----------------------------------------------------------------------------
module accel_stream_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_FRAME_LEN = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  accel_stream_arbiter_if.slave  s00_axis,
  accel_stream_arbiter_if.slave  s01_axis,
  accel_stream_arbiter_if.master m00_axis,
  output logic [CNT_WIDTH-1:0]  frame_cnt0,
  output logic [CNT_WIDTH-1:0]  frame_cnt1,
  output logic                  trunc_err
);

  // One extra bit over clog2 so the counter can never wrap within a frame.
  localparam int                BEAT_W    = $clog2(MAX_FRAME_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic [BEAT_W-1:0]     beat_cnt;

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  granted;
  logic                  grant_idx;
  logic                  src_last;
  logic                  eff_last;
  logic                  accept;

  // Next-state decode plus the zero-latency datapath mux selected by state.
  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_nxt        = state;
    mux_data         = '0;
    granted          = 1'b0;
    grant_idx        = 1'b0;
    src_last         = 1'b0;
    m00_axis.tvalid  = 1'b0;
    s00_axis.tready  = 1'b0;
    s01_axis.tready  = 1'b0;

    case (state)
      IDLE: begin
        // Arbitration bubble: nothing is accepted while the decision is made.
        if (s00_axis.tvalid && s01_axis.tvalid) begin
          state_nxt = last_grant ? GRANT0 : GRANT1;
        end else if (s00_axis.tvalid) begin
          state_nxt = GRANT0;
        end else if (s01_axis.tvalid) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        granted         = 1'b1;
        grant_idx       = 1'b0;
        m00_axis.tvalid = s00_axis.tvalid;
        mux_data        = s00_axis.tdata;
        src_last        = s00_axis.tlast;
        s00_axis.tready = m00_axis.tready;
      end
      GRANT1: begin
        granted         = 1'b1;
        grant_idx       = 1'b1;
        m00_axis.tvalid = s01_axis.tvalid;
        mux_data        = s01_axis.tdata;
        src_last        = s01_axis.tlast;
        s01_axis.tready = m00_axis.tready;
      end
      default: state_nxt = IDLE;
    endcase

    // The source's own tlast, or the length limit reached on this beat.
    eff_last       = granted & (src_last | (beat_cnt == LAST_BEAT));
    accept         = m00_axis.tvalid & m00_axis.tready;

    m00_axis.tdata = mux_data;
    m00_axis.tlast = eff_last;
    m00_axis.tid   = grant_idx;

    if (accept && eff_last) begin
      state_nxt = IDLE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // s00 wins the first contended arbitration
      beat_cnt   <= '0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      trunc_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (eff_last) begin
          beat_cnt   <= '0;
          last_grant <= grant_idx;
          if (grant_idx) begin
            frame_cnt1 <= frame_cnt1 + 1'b1;
          end else begin
            frame_cnt0 <= frame_cnt0 + 1'b1;
          end
          // Forced end: the source's remaining beats become its next frame.
          if (!src_last) begin
            trunc_err <= 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_accel_stream_arbiter
//   Randomized and directed stimulus for accel_stream_arbiter. Each source's
//   beats are pushed into a driver queue; at the same time the expected output
//   beats (with the effective tlast implied by the length limit) are pushed into
//   a per-source scoreboard queue. An independent monitor pops and compares on
//   every accepted output beat. A second instance with MAX_FRAME_LEN = 1 and a
//   narrow counter covers single-beat frames and counter wrap.
// -----------------------------------------------------------------------------
module tb_accel_stream_arbiter;

  localparam int DW   = 32;
  localparam int MAXL = 64;
  localparam int CW   = 16;
  localparam int CW1  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accel_stream_arbiter_if #(.DATA_WIDTH(DW)) s00 ();
  accel_stream_arbiter_if #(.DATA_WIDTH(DW)) s01 ();
  accel_stream_arbiter_if #(.DATA_WIDTH(DW)) m00 ();
  accel_stream_arbiter_if #(.DATA_WIDTH(DW)) a00 ();
  accel_stream_arbiter_if #(.DATA_WIDTH(DW)) a01 ();
  accel_stream_arbiter_if #(.DATA_WIDTH(DW)) am  ();

  logic [CW-1:0]  frame_cnt0, frame_cnt1;
  logic           trunc_err;
  logic [CW1-1:0] sc0, sc1;
  logic           strunc;

  accel_stream_arbiter #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXL), .CNT_WIDTH(CW)) u_dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (s00),
    .s01_axis         (s01),
    .m00_axis         (m00),
    .frame_cnt0       (frame_cnt0),
    .frame_cnt1       (frame_cnt1),
    .trunc_err        (trunc_err)
  );

  accel_stream_arbiter #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(1), .CNT_WIDTH(CW1)) u_dut_short (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (a00),
    .s01_axis         (a01),
    .m00_axis         (am),
    .frame_cnt0       (sc0),
    .frame_cnt1       (sc1),
    .trunc_err        (strunc)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t src_q[2][$];   // beats still to be offered by each source
  beat_t exp_q[2][$];   // beats expected on m00, per source, in order
  int    order_q[$];    // expected source of successive frames (when known)

  int checks   = 0;
  int failures = 0;

  int  exp_frames[2];
  bit  exp_trunc;
  int  pos[2];          // model: beats already sent in the current output frame
  int  beats_seen[2];
  bit  in_frame, after_last, gap_pending;
  int  cur_tid;
  int  vprob[2];
  int  ready_mode;      // 0 always, 1 toggle, 2 random, 3 hold
  bit  acc0, acc1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the output for one source is its own beat sequence, with
  // tlast also set on every MAX-th beat since the previous output frame end.
  task automatic push_frame(int x, int len, bit with_last, bit seq);
    for (int i = 0; i < len; i++) begin
      beat_t b, e;
      b.data = seq ? DW'(i + 1) : DW'($urandom);
      b.last = with_last && (i == len - 1);
      e      = b;
      e.last = b.last || (pos[x] == MAXL - 1);
      if (e.last) begin
        exp_frames[x]++;
        if (!b.last) exp_trunc = 1'b1;
        pos[x] = 0;
      end else begin
        pos[x]++;
      end
      src_q[x].push_back(b);
      exp_q[x].push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      src_q[x].delete();
      exp_q[x].delete();
      exp_frames[x] = 0;
      pos[x]        = 0;
    end
    order_q.delete();
    exp_trunc   = 1'b0;
    in_frame    = 1'b0;
    after_last  = 1'b0;
    gap_pending = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(n < budget), 64'(1));
    repeat (3) @(posedge clk);
  endtask

  task automatic check_counts(string name);
    @(negedge clk);
    check({name, "_frame_cnt0"}, 64'(frame_cnt0), 64'(exp_frames[0] % (1 << CW)));
    check({name, "_frame_cnt1"}, 64'(frame_cnt1), 64'(exp_frames[1] % (1 << CW)));
    check({name, "_trunc_err"},  64'(trunc_err),  64'(exp_trunc));
  endtask

  // Source drivers: hold a presented beat until accepted, otherwise offer the
  // next beat with probability vprob.
  initial begin : drv0
    s00.tvalid = 1'b0; s00.tdata = '0; s00.tlast = 1'b0; s00.tid = 1'b0;
    forever begin
      @(negedge clk);
      acc0 = s00.tvalid && s00.tready;
      @(posedge clk); #1;
      if (acc0 && src_q[0].size() > 0) void'(src_q[0].pop_front());
      if (src_q[0].size() > 0 &&
          ((s00.tvalid && !acc0) || $urandom_range(99) < vprob[0])) begin
        s00.tvalid = 1'b1;
        s00.tdata  = src_q[0][0].data;
        s00.tlast  = src_q[0][0].last;
      end else begin
        s00.tvalid = 1'b0;
      end
    end
  end

  initial begin : drv1
    s01.tvalid = 1'b0; s01.tdata = '0; s01.tlast = 1'b0; s01.tid = 1'b0;
    forever begin
      @(negedge clk);
      acc1 = s01.tvalid && s01.tready;
      @(posedge clk); #1;
      if (acc1 && src_q[1].size() > 0) void'(src_q[1].pop_front());
      if (src_q[1].size() > 0 &&
          ((s01.tvalid && !acc1) || $urandom_range(99) < vprob[1])) begin
        s01.tvalid = 1'b1;
        s01.tdata  = src_q[1][0].data;
        s01.tlast  = src_q[1][0].last;
      end else begin
        s01.tvalid = 1'b0;
      end
    end
  end

  initial begin : drv_ready
    m00.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m00.tready = 1'b1;
        1:       m00.tready = ~m00.tready;
        2:       m00.tready = 1'($urandom_range(1));
        default: ;
      endcase
    end
  end

  // Monitor: compares every accepted m00 beat against the scoreboard.
  initial begin : monitor
    beat_t e;
    int    t;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (gap_pending) begin
        check("one_bubble", 64'(m00.tvalid), 64'(1));
        gap_pending = 1'b0;
      end
      if (after_last) begin
        check("idle_after_last", 64'(m00.tvalid), 64'(0));
        after_last  = 1'b0;
        gap_pending = (vprob[0] == 100) && (vprob[1] == 100) &&
                      (exp_q[0].size() + exp_q[1].size() > 0);
      end
      if (m00.tvalid) begin
        t = int'(m00.tid);
        check("other_tready_low", 64'(t ? s00.tready : s01.tready), 64'(0));
        check("granted_tready", 64'(t ? s01.tready : s00.tready), 64'(m00.tready));
        if (m00.tready) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            cur_tid  = t;
            if (order_q.size() > 0) check("grant_order", 64'(t), 64'(order_q.pop_front()));
          end else begin
            check("no_interleave", 64'(t), 64'(cur_tid));
          end
          if (exp_q[t].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: tid %0d data %0h, none expected", t, m00.tdata);
          end else begin
            e = exp_q[t].pop_front();
            check("beat_data", 64'(m00.tdata), 64'(e.data));
            check("beat_last", 64'(m00.tlast), 64'(e.last));
          end
          beats_seen[t]++;
          if (m00.tlast) begin
            in_frame   = 1'b0;
            after_last = 1'b1;
          end
        end
      end
    end
  end

  // Single-beat-frame instance: every frame is one beat with tlast.
  int short_total = 0;
  logic [DW-1:0] short_data = '0;

  task automatic run_short(int nframes);
    int got = 0;
    int n   = 0;
    @(posedge clk); #1;
    short_data = short_data + 1;
    a00.tvalid = 1'b1;
    a00.tlast  = 1'b1;
    a00.tdata  = short_data;
    while (got < nframes && n < 2000) begin
      @(negedge clk);
      n++;
      if (am.tvalid && am.tready) begin
        check("short_last", 64'(am.tlast), 64'(1));
        check("short_data", 64'(am.tdata), 64'(short_data));
        got++;
        @(posedge clk); #1;
        if (got == nframes) begin
          a00.tvalid = 1'b0;
        end else begin
          short_data = short_data + 1;
          a00.tdata  = short_data;
        end
      end
    end
    check("short_done", 64'(got), 64'(nframes));
    short_total += nframes;
    @(negedge clk);
    check("short_frame_cnt0", 64'(sc0), 64'(short_total % (1 << CW1)));
    check("short_trunc_err",  64'(strunc), 64'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int base, n;
    vprob      = '{100, 100};
    ready_mode = 0;
    beats_seen = '{0, 0};
    model_reset();
    a00.tvalid = 1'b0; a00.tdata = '0; a00.tlast = 1'b0; a00.tid = 1'b0;
    a01.tvalid = 1'b0; a01.tdata = '0; a01.tlast = 1'b0; a01.tid = 1'b0;
    am.tready  = 1'b1;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", 64'(m00.tvalid), 64'(0));
    check("rst_m_tdata",  64'(m00.tdata),  64'(0));
    check("rst_m_tlast",  64'(m00.tlast),  64'(0));
    check("rst_m_tid",    64'(m00.tid),    64'(0));
    check("rst_s0_ready", 64'(s00.tready), 64'(0));
    check("rst_s1_ready", 64'(s01.tready), 64'(0));
    check("rst_cnt0",     64'(frame_cnt0), 64'(0));
    check("rst_cnt1",     64'(frame_cnt1), 64'(0));
    check("rst_trunc",    64'(trunc_err),  64'(0));
    rst_n = 1'b1;

    // Single 50-beat frame from s00, data 1..50.
    @(negedge clk);
    order_q.push_back(0);
    push_frame(0, 50, 1'b1, 1'b1);
    wait_drain("single", 2000);
    check_counts("single");

    // Contention after reset: s00, s01, s00, s01.
    pulse_reset();
    push_frame(0, 50, 1'b1, 1'b0);
    push_frame(0, 50, 1'b1, 1'b0);
    push_frame(1, 50, 1'b1, 1'b0);
    push_frame(1, 50, 1'b1, 1'b0);
    order_q = '{0, 1, 0, 1};
    wait_drain("contend", 2000);
    check_counts("contend");

    // 70-beat s01 frame: cut at 64, remaining 6 form the next frame.
    @(negedge clk);
    order_q = '{1, 1};
    push_frame(1, 70, 1'b1, 1'b0);
    wait_drain("trunc", 2000);
    check_counts("trunc");

    // Toggling backpressure; s01 waits for s00's frame, then is cut at 64.
    ready_mode = 1;
    @(negedge clk);
    order_q = '{0, 1, 1};
    push_frame(0, 50, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    push_frame(1, 70, 1'b1, 1'b0);
    wait_drain("stall", 4000);
    check_counts("stall");

    // Randomized traffic, lengths and backpressure.
    ready_mode = 2;
    vprob      = '{30 + $urandom_range(70), 30 + $urandom_range(70)};
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      push_frame($urandom_range(1), 1 + $urandom_range(89), $urandom_range(3) != 0, 1'b0);
    end
    push_frame(0, 1, 1'b1, 1'b0);
    push_frame(1, 1, 1'b1, 1'b0);
    wait_drain("random", 30000);
    check_counts("random");

    // Reset in the middle of an s01 frame.
    ready_mode = 0;
    vprob      = '{100, 100};
    @(negedge clk);
    push_frame(1, 40, 1'b1, 1'b0);
    base = beats_seen[1];
    n    = 0;
    while (beats_seen[1] < base + 20 && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    check("midrst_reached", 64'(n < 2000), 64'(1));
    ready_mode = 3;
    m00.tready = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    @(posedge clk); #2;
    rst_n      = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    check("midrst_tvalid", 64'(m00.tvalid), 64'(0));
    check("midrst_cnt1",   64'(frame_cnt1), 64'(0));
    check("midrst_trunc",  64'(trunc_err),  64'(0));
    push_frame(0, 10, 1'b1, 1'b0);
    push_frame(1, 10, 1'b1, 1'b0);
    order_q = '{0, 1};
    wait_drain("postrst", 2000);
    check_counts("postrst");

    // Single-beat frames: counter preloaded to all-ones, then wraps to zero.
    run_short((1 << CW1) - 1);
    run_short(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accel_stream_arbiter.md
Name: accel_stream_arbiter

Overview:
- Frame-granular round-robin arbiter sharing the single AXI-Stream input of accelerator_v1_0 between two stream sources (s00, s01).
- A grant is held for a whole frame and released only on the accepted last beat, so frames from the two sources never interleave inside the accelerator's accumulators.
- Enforces a maximum frame length by forcing tlast.
- Reports per-source frame counts and a sticky truncation flag for the PS.

Parameters:
- DATA_WIDTH, 32, tdata width of all stream ports.
- MAX_FRAME_LEN, 64, maximum beats per frame; the arbiter forces tlast on beat MAX_FRAME_LEN (range 1..1024).
- CNT_WIDTH, 16, width of the frame counters.

Ports:
- s00_axis_aclk  in  1  single clock for all interfaces.
- s00_axis_aresetn  in  1  reset, synchronous, active-low.
- s00_axis_tdata  in  DATA_WIDTH  source 0 data.
- s00_axis_tlast  in  1  source 0 end of frame.
- s00_axis_tvalid  in  1  source 0 valid.
- s00_axis_tready  out  1  source 0 ready.
- s01_axis_tdata  in  DATA_WIDTH  source 1 data.
- s01_axis_tlast  in  1  source 1 end of frame.
- s01_axis_tvalid  in  1  source 1 valid.
- s01_axis_tready  out  1  source 1 ready.
- m00_axis_tdata  out  DATA_WIDTH  data to the accelerator.
- m00_axis_tlast  out  1  effective end of frame.
- m00_axis_tvalid  out  1  valid to the accelerator.
- m00_axis_tready  in  1  accelerator ready.
- m00_axis_tid  out  1  index of the granted source.
- frame_cnt0  out  CNT_WIDTH  frames completed from s00.
- frame_cnt1  out  CNT_WIDTH  frames completed from s01.
- trunc_err  out  1  sticky: a frame was cut at MAX_FRAME_LEN.

Behaviour:
- Reset (aresetn=0 at a clock edge) clears:
  - state to IDLE, last_grant to 1, beat_cnt to 0.
  - frame_cnt0 and frame_cnt1 to 0, trunc_err to 0.
  - All tready and m00_axis_tvalid are 0 while in IDLE.
  - m00_axis_tdata, m00_axis_tlast and m00_axis_tid are 0 in IDLE.
- FSM states: IDLE, GRANT0, GRANT1. State is registered; the datapath is a combinational mux selected by state.
- IDLE:
  - No tready is asserted.
  - Arbitration uses the tvalid values sampled in IDLE.
  - Only s00 valid -> GRANT0. Only s01 valid -> GRANT1.
  - Both valid -> grant the source that is not last_grant.
  - Neither valid -> stay in IDLE.
  - Cost: one bubble cycle per frame.
- GRANTx (x = 0 or 1):
  - m00_axis_tvalid = s0x_axis_tvalid, m00_axis_tdata = s0x_axis_tdata, m00_axis_tid = x.
  - s0x_axis_tready = m00_axis_tready; the other source's tready = 0.
  - Effective last = s0x_axis_tlast OR (beat_cnt == MAX_FRAME_LEN-1); this drives m00_axis_tlast.
  - The granted path has zero latency; there is no buffering.
- Beat accepted = m00_axis_tvalid AND m00_axis_tready.
  - Accepted, not last: beat_cnt increments.
  - Accepted and last: beat_cnt <- 0, frame_cntx increments, last_grant <- x, state -> IDLE.
  - Last forced while s0x_axis_tlast = 0: trunc_err <- 1, held until reset. The source's remaining beats form its next frame.
- The grant never changes mid-frame, regardless of the other source's tvalid.
- tvalid may drop mid-frame: the arbiter holds GRANTx with beat_cnt unchanged.
- Backpressure (m00_axis_tready = 0): no counter advances; the source holds its data per AXIS rules.
- MAX_FRAME_LEN = 1: every beat is last; tlast is always 1 in GRANT.
- Frame counters wrap modulo 2^CNT_WIDTH with no flag.
- Reset mid-frame: the FSM returns to IDLE on that edge. The partial frame is abandoned and the accelerator sees tvalid fall. Counters are cleared and the first grant after reset goes to s00 under contention.
- beat_cnt is clog2(MAX_FRAME_LEN)+1 bits wide, so it does not overflow.

Test Plan:
- Reset, then s00 sends one 50-beat frame (data 1..50, tlast on 50); m00_axis_tready = 1 -> m00 carries 1..50 with tid = 0, tlast on beat 50, frame_cnt0 = 1, state IDLE one cycle later.
- Both sources valid in the same cycle, each sending 50-beat frames -> order is s00, s01, s00, s01 with no interleaving. After 4 frames: frame_cnt0 = 2, frame_cnt1 = 2, one idle cycle between frames.
- s01 sends 70 beats with no tlast, MAX_FRAME_LEN = 64 -> m00_axis_tlast on beat 64 and trunc_err = 1. The remaining 6 beats form a second frame after re-arbitration, ending on s01's own tlast; frame_cnt1 = 2.
- During a 50-beat s00 frame, m00_axis_tready toggles 1/0 each cycle and s01 asserts tvalid -> all 50 beats are delivered in order, s01_axis_tready stays 0 until s00's tlast is accepted, and beat_cnt holds on stalled cycles.
- aresetn pulled low for 1 cycle at beat 20 of an s01 frame -> next cycle m00_axis_tvalid = 0, frame_cnt1 = 0, trunc_err = 0. With both sources valid afterwards, s00 is granted first.
- Preload frame_cnt0 to 16'hFFFF via 65535 one-beat frames with MAX_FRAME_LEN = 1, then send one more frame -> frame_cnt0 wraps to 0 and trunc_err remains 0 if the source drove tlast.
